// File: rtl/gsm_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gsm_mul_pkg
// Description : Shared widths, result-mode encoding and rounding constants
//               for the GSM shared-multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package gsm_mul_pkg;

   localparam int OPW = 16;
   localparam int PW  = 32;

   typedef enum logic {
      MODE_EXACT  = 1'b0,
      MODE_MULT_R = 1'b1
   } mode_e;

   localparam logic signed [PW-1:0]  RND_HALF = 32'sd16384;
   localparam logic signed [PW-1:0]  SAT_MAX  = 32'sd32767;
   localparam logic signed [OPW-1:0] MIN16    = 16'sh8000;

   // Ceiling log2, used to size requester indices
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gsm_mul16_pipe.sv
`default_nettype none
// ============================================================================
// Module      : gsm_mul16_pipe
// Description : Signed 16x16->32 multiply followed by MUL_STAGES enable-gated
//               registers carrying valid, requester id, result mode and the
//               "both operands are -32768" flag used for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module gsm_mul16_pipe
   import gsm_mul_pkg::*;
#(
   parameter int MUL_STAGES = 2,
   parameter int ID_W       = 2
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_en,
   input  logic                  i_valid,
   input  logic [ID_W-1:0]       i_id,
   input  mode_e                 i_mode,
   input  logic signed [OPW-1:0] i_a,
   input  logic signed [OPW-1:0] i_b,
   output logic                  o_valid,
   output logic [ID_W-1:0]       o_id,
   output mode_e                 o_mode,
   output logic                  o_min_pair,
   output logic signed [PW-1:0]  o_p,
   output logic                  o_any_valid
);

   logic                 r_valid    [MUL_STAGES];
   logic [ID_W-1:0]      r_id       [MUL_STAGES];
   mode_e                r_mode     [MUL_STAGES];
   logic                 r_min_pair [MUL_STAGES];
   logic signed [PW-1:0] r_p        [MUL_STAGES];

   logic signed [PW-1:0] w_prod;
   logic                 w_min_pair;
   logic                 w_any;

   // Full-width product: -32768*-32768 must not wrap
   assign w_prod     = PW'(i_a) * PW'(i_b);
   assign w_min_pair = (i_a == MIN16) && (i_b == MIN16);

   // Shift register of stage contents, all stages advance together on i_en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < MUL_STAGES; s++) begin
            r_valid[s]    <= 1'b0;
            r_id[s]       <= '0;
            r_mode[s]     <= MODE_EXACT;
            r_min_pair[s] <= 1'b0;
            r_p[s]        <= '0;
         end
      end else if (i_en) begin
         r_valid[0]    <= i_valid;
         r_id[0]       <= i_id;
         r_mode[0]     <= i_mode;
         r_min_pair[0] <= w_min_pair;
         r_p[0]        <= w_prod;
         for (int s = 1; s < MUL_STAGES; s++) begin
            r_valid[s]    <= r_valid[s-1];
            r_id[s]       <= r_id[s-1];
            r_mode[s]     <= r_mode[s-1];
            r_min_pair[s] <= r_min_pair[s-1];
            r_p[s]        <= r_p[s-1];
         end
      end
   end

   // Occupancy summary across every stage
   always_comb begin
      w_any = 1'b0;
      for (int s = 0; s < MUL_STAGES; s++) begin
         w_any = w_any | r_valid[s];
      end
   end

   assign o_valid     = r_valid[MUL_STAGES-1];
   assign o_id        = r_id[MUL_STAGES-1];
   assign o_mode      = r_mode[MUL_STAGES-1];
   assign o_min_pair  = r_min_pair[MUL_STAGES-1];
   assign o_p         = r_p[MUL_STAGES-1];
   assign o_any_valid = w_any;

endmodule
`default_nettype wire

// File: rtl/gsm_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gsm_mul_share_arbiter
// Description : Round-robin arbiter sharing one signed 16x16 multiplier
//               pipeline among NUM_REQ requesters; results are tagged with
//               the issuing requester and optionally rounded to Q15 with
//               saturation (GSM_MULT_R) in the final output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module gsm_mul_share_arbiter
   import gsm_mul_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int MUL_STAGES = 2,
   parameter int ID_W       = 2
)(
   input  logic                   ap_clk,
   input  logic                   ap_rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [16*NUM_REQ-1:0]  req_a,
   input  logic [16*NUM_REQ-1:0]  req_b,
   input  logic [NUM_REQ-1:0]     req_mode,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [31:0]            rsp_p,
   output logic                   busy
);

   logic [ID_W-1:0]      r_last_gnt;
   logic                 r_rsp_valid;
   logic [ID_W-1:0]      r_rsp_id;
   logic signed [PW-1:0] r_rsp_p;

   logic                  w_adv;
   logic                  w_any_req;
   logic                  w_hi_found;
   logic [ID_W-1:0]       w_hi_idx;
   logic [ID_W-1:0]       w_lo_idx;
   logic [ID_W-1:0]       w_gnt_idx;
   logic [NUM_REQ-1:0]    w_req_ready;
   logic                  w_accept;
   logic signed [OPW-1:0] w_a;
   logic signed [OPW-1:0] w_b;
   mode_e                 w_mode;

   logic                 w_pipe_valid;
   logic [ID_W-1:0]      w_pipe_id;
   mode_e                w_pipe_mode;
   logic                 w_pipe_min_pair;
   logic signed [PW-1:0] w_pipe_p;
   logic                 w_pipe_any;
   logic signed [PW-1:0] w_rnd;
   logic signed [PW-1:0] w_result;

   // Whole pipeline moves only when the output slot is free or being popped
   assign w_adv = !r_rsp_valid | rsp_ready;

   // Round-robin pick: lowest valid index above last_gnt, else lowest overall
   always_comb begin
      w_any_req  = 1'b0;
      w_hi_found = 1'b0;
      w_hi_idx   = '0;
      w_lo_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            w_any_req = 1'b1;
            w_lo_idx  = ID_W'(i);
            if (ID_W'(i) > r_last_gnt) begin
               w_hi_found = 1'b1;
               w_hi_idx   = ID_W'(i);
            end
         end
      end
      w_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;
   end

   // One-hot ready for the winner plus operand/mode mux into the multiplier
   always_comb begin
      w_req_ready = '0;
      w_a         = '0;
      w_b         = '0;
      w_mode      = MODE_EXACT;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt_idx == ID_W'(i)) begin
            w_req_ready[i] = w_adv & w_any_req & ap_rst_n;
            w_a            = req_a[i*OPW +: OPW];
            w_b            = req_b[i*OPW +: OPW];
            w_mode         = mode_e'(req_mode[i]);
         end
      end
   end

   assign req_ready = w_req_ready;
   assign w_accept  = |(req_valid & w_req_ready);

   // Round-robin pointer moves only on a completed handshake
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_last_gnt <= ID_W'(NUM_REQ - 1);
      end else if (w_accept) begin
         r_last_gnt <= w_gnt_idx;
      end
   end

   gsm_mul16_pipe #(
      .MUL_STAGES (MUL_STAGES),
      .ID_W       (ID_W)
   ) u_pipe (
      .clk         (ap_clk),
      .rst_n       (ap_rst_n),
      .i_en        (w_adv),
      .i_valid     (w_accept),
      .i_id        (w_gnt_idx),
      .i_mode      (w_mode),
      .i_a         (w_a),
      .i_b         (w_b),
      .o_valid     (w_pipe_valid),
      .o_id        (w_pipe_id),
      .o_mode      (w_pipe_mode),
      .o_min_pair  (w_pipe_min_pair),
      .o_p         (w_pipe_p),
      .o_any_valid (w_pipe_any)
   );

   // Q15 rounding; only -32768*-32768 can leave 16-bit range, so it saturates
   assign w_rnd    = w_pipe_p + RND_HALF;
   assign w_result = (w_pipe_mode == MODE_EXACT) ? w_pipe_p :
                     (w_pipe_min_pair ? SAT_MAX : (w_rnd >>> 15));

   // Output stage; holds while the consumer stalls
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_p     <= '0;
      end else if (w_adv) begin
         r_rsp_valid <= w_pipe_valid;
         if (w_pipe_valid) begin
            r_rsp_id <= w_pipe_id;
            r_rsp_p  <= w_result;
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_p     = r_rsp_p;
   assign busy      = w_pipe_any | r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_gsm_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gsm_mul_share_arbiter
// Description : Self-checking bench for gsm_mul_share_arbiter: directed
//               latency, arithmetic, fairness, backpressure and reset cases
//               followed by a randomized soak against a latency/order model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gsm_mul_share_arbiter;

   localparam int N   = 4;
   localparam int MS  = 2;
   localparam int IDW = 2;

   logic           ap_clk    = 1'b0;
   logic           ap_rst_n  = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [16*N-1:0] req_a    = '0;
   logic [16*N-1:0] req_b    = '0;
   logic [N-1:0]   req_mode  = '0;
   logic           rsp_valid;
   logic           rsp_ready = 1'b1;
   logic [IDW-1:0] rsp_id;
   logic [31:0]    rsp_p;
   logic           busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Operands currently presented by each requester
   int op_a [N];
   int op_b [N];
   bit op_m [N];

   // Reference model: RR pointer plus in-flight queue with advance counts
   int     m_last = N - 1;
   int     q_id  [$];
   longint q_p   [$];
   int     q_age [$];

   bit acc_fire;
   int acc_id;
   int obs_gnt;

   gsm_mul_share_arbiter #(
      .NUM_REQ    (N),
      .MUL_STAGES (MS),
      .ID_W       (IDW)
   ) dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_mode  (req_mode),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_p     (rsp_p),
      .busy      (busy)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint ref_result(input int a, input int b, input bit mode);
      longint p;
      p = longint'(a) * longint'(b);
      if (!mode) return p;
      if (a == -32768 && b == -32768) return 32767;
      return (p + 16384) >>> 15;
   endfunction

   function automatic int rand_op();
      int tbl [7] = '{-32768, 32767, 16384, -16384, 0, 1, -1};
      if ($urandom_range(0, 7) == 0) return tbl[$urandom_range(0, 6)];
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   task automatic update_bus();
      for (int i = 0; i < N; i++) begin
         req_a[i*16 +: 16] = op_a[i][15:0];
         req_b[i*16 +: 16] = op_b[i][15:0];
         req_mode[i]       = op_m[i];
      end
   endtask

   task automatic set_req(input int i, input int a, input int b, input bit m);
      op_a[i] = a;
      op_b[i] = b;
      op_m[i] = m;
      req_valid[i] = 1'b1;
      update_bus();
   endtask

   // One clock: compare outputs mid-cycle, then advance the model over the edge
   task automatic step();
      bit           ev;
      bit           adv;
      int           g;
      int           idx;
      logic [N-1:0] er;
      @(negedge ap_clk);
      ev  = (q_id.size() > 0) && (q_age[0] > MS);
      adv = !ev || rsp_ready;
      g   = -1;
      if (adv) begin
         for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      check("req_ready", req_ready, er);
      check("rsp_valid", rsp_valid, ev);
      check("busy", busy, q_id.size() > 0);
      if (ev) begin
         check("rsp_id", rsp_id, q_id[0]);
         check("rsp_p", $signed(rsp_p), q_p[0]);
      end
      obs_gnt = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) obs_gnt = i;
      if (ev && rsp_ready) begin
         void'(q_id.pop_front());
         void'(q_p.pop_front());
         void'(q_age.pop_front());
      end
      if (adv) foreach (q_age[j]) q_age[j]++;
      acc_fire = (g >= 0);
      acc_id   = g;
      if (g >= 0) begin
         q_id.push_back(g);
         q_p.push_back(ref_result(op_a[g], op_b[g], op_m[g]));
         q_age.push_back(1);
         m_last = g;
      end
      @(posedge ap_clk);
      #1;
   endtask

   // Asynchronous reset away from any clock edge; outputs must clear at once
   task automatic apply_reset();
      @(negedge ap_clk);
      #2;
      ap_rst_n = 1'b0;
      #1;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_p", rsp_p, 0);
      req_valid = '0;
      q_id.delete();
      q_p.delete();
      q_age.delete();
      m_last = N - 1;
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
   endtask

   task automatic drain(input string tag);
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (q_id.size() == 0) break;
         step();
      end
      check(tag, q_id.size(), 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   task automatic run_single(input int i, input int a, input int b, input bit m,
                             input longint exp_p);
      bit got;
      got = 1'b0;
      rsp_ready = 1'b1;
      set_req(i, a, b, m);
      for (int k = 0; k < 10; k++) begin
         step();
         if (acc_fire && acc_id == i) begin
            got = 1'b1;
            break;
         end
      end
      req_valid[i] = 1'b0;
      check("single_accept", got, 1);
      if (got) begin
         for (int k = 0; k < MS - 1; k++) step();
         check("lat_early", rsp_valid, 0);
         step();
         check("lat_valid", rsp_valid, 1);
         check("single_id", rsp_id, i);
         check("single_p", $signed(rsp_p), exp_p);
         step();
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp2 [6] = '{0, 2, 3, 0, 2, 3};
      int cnt;
      for (int i = 0; i < N; i++) begin
         op_a[i] = 0;
         op_b[i] = 0;
         op_m[i] = 1'b0;
      end
      req_valid = '1;
      apply_reset();

      // Single request and arithmetic boundaries
      run_single(2, 3, -4, 1'b0, -12);
      run_single(0, -32768, -32768, 1'b0, 64'sh40000000);
      run_single(1, -32768, -32768, 1'b1, 32767);
      run_single(3, 16384, 16384, 1'b1, 8192);
      run_single(2, -16384, 16384, 1'b1, -8192);
      drain("drain_single");

      // Fairness with all requesters, then with requester 1 idle
      apply_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, i + 1, 100, 1'b0);
      for (int n = 0; n < 8; n++) begin
         step();
         check("fair_gnt", obs_gnt, n % 4);
         if (acc_fire) set_req(acc_id, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      end
      req_valid[1] = 1'b0;
      for (int n = 0; n < 6; n++) begin
         step();
         check("fair_skip_gnt", obs_gnt, exp2[n]);
         if (acc_fire) set_req(acc_id, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      end
      drain("drain_fair");

      // Backpressure: fill, stall 5 cycles, then drain
      rsp_ready = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 20; k++) begin
         if (q_id.size() == MS + 1) break;
         step();
         if (acc_fire) set_req(acc_id, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      end
      check("bp_fill_rsp_valid", rsp_valid, 1);
      for (int k = 0; k < 5; k++) begin
         step();
         check("bp_ready_zero", req_ready, 0);
      end
      drain("drain_bp");

      // Reset with two operations in flight
      rsp_ready = 1'b1;
      set_req(0, 11, 12, 1'b0);
      set_req(1, 13, 14, 1'b0);
      cnt = 0;
      for (int k = 0; k < 10 && cnt < 2; k++) begin
         step();
         if (acc_fire) begin
            req_valid[acc_id] = 1'b0;
            cnt++;
         end
      end
      check("pre_rst_busy", busy, q_id.size() > 0);
      apply_reset();
      run_single(3, 5, 7, 1'b0, 35);
      drain("drain_rst");
      apply_reset();
      for (int i = 0; i < N; i++) set_req(i, rand_op(), rand_op(), 1'b0);
      step();
      check("rst_first_gnt", obs_gnt, 0);
      drain("drain_rst2");

      // Random soak
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 1) == 1)
               set_req(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
         if (acc_fire) req_valid[acc_id] = 1'b0;
      end
      drain("drain_soak");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gsm_mul_share_arbiter.md
Name: gsm_mul_share_arbiter

Overview:
Shares one signed 16x16 multiplier datapath among NUM_REQ requesters inside the GSM LPC analysis path, for example the autocorrelation, reflection and quantisation loops.
- Arbitrates round-robin with a valid/ready handshake on each requester.
- Feeds a MUL_STAGES-deep enable-gated multiplier pipeline.
- Returns each result tagged with the requester index.
- Supports two result modes: exact product, or GSM_MULT_R (rounded Q15 with saturation).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MUL_STAGES, 2, multiplier pipeline depth in cycles (1..4).
- ID_W, 2, width of the requester tag; must be at least clog2(NUM_REQ).

Ports:
- ap_clk  in  1  sole clock; all state changes on the rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  16*NUM_REQ  signed operand a; slice i belongs to requester i.
- req_b  in  16*NUM_REQ  signed operand b; slice i.
- req_mode  in  NUM_REQ  0 = exact product, 1 = GSM_MULT_R; bit i.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_id  out  ID_W  index of the requester that issued the result.
- rsp_p  out  32  signed result.
- busy  out  1  at least one pipeline stage is occupied.

Behaviour:
- Reset while ap_rst_n is low, applied asynchronously:
  - rsp_valid, req_ready, busy, rsp_id and rsp_p all 0.
  - All stage-valid bits cleared.
  - RR pointer last_gnt = NUM_REQ-1, so requester 0 has highest priority first.
- Reset asserted mid-operation flushes in-flight operations with no response. The requester must re-present its operation.
- Pipeline advance: adv = !rsp_valid | rsp_ready. All stages move together only when adv=1; otherwise every stage holds, and rsp_valid, rsp_id and rsp_p stay stable.
- Grant (combinational):
  - If adv=1, grant the first requester with req_valid=1, scanning from last_gnt+1 modulo NUM_REQ.
  - req_ready[g] = 1 only for the granted requester. With adv=0, req_ready = 0.
  - The handshake completes when req_valid[i] & req_ready[i]. last_gnt updates to i on that edge only.
- Round-robin is work-conserving: an idle requester is skipped with no bubble.
- Throughput: one accept per cycle while rsp_ready=1.
- Latency: an operation accepted at edge k presents rsp_valid=1 at edge k+MUL_STAGES when no stall occurs. Each stall cycle adds one cycle.
- Ordering: responses appear in acceptance order.
- Arithmetic: the full 32-bit signed product is formed internally (P = a*b), so -32768*-32768 = 0x40000000 with no 31-bit wrap.
  - Mode 0: rsp_p = P.
  - Mode 1: if a = b = -32768, rsp_p = 32767. Otherwise rsp_p = sign-extend((P + 16384) >>> 15), an arithmetic shift whose result is always in 16-bit range.
- Mode and ID travel through the pipeline with the operands. Rounding and saturation are applied in the final stage.
- Boundaries:
  - Pipeline full with rsp_ready=0: no grant issues and no data is lost.
  - Simultaneous response pop and new accept in the same cycle is allowed.
  - A requester must hold req_valid and its operands stable until accepted; the block does not check this.
- busy = OR of all stage-valid bits.

Decomposition:
- Package gsm_mul_pkg:
  - OPW = 16, PW = 32.
  - Mode enum: MODE_EXACT = 0, MODE_MULT_R = 1.
  - RND_HALF = 16384, SAT_MAX = 32767, MIN16 = -32768.
  - clog2 helper function.
- Sub-module gsm_mul16_pipe: signed 16x16 to 32 multiply plus MUL_STAGES enable-gated registers carrying {valid, id, mode, a_is_min & b_is_min}, with async active-low reset. The top level holds the arbiter, the RR pointer and the final round/saturate stage.

Test Plan:
- Single request, MUL_STAGES=2: requester 2 sends a=3, b=-4, mode 0. Expect rsp_valid exactly 2 cycles after accept, rsp_id=2, rsp_p=-12.
- Mode and boundary values:
  - -32768 * -32768, mode 0 -> 0x40000000.
  - Same operands, mode 1 -> 32767.
  - 16384 * 16384, mode 1 -> 8192.
  - -16384 * 16384, mode 1 -> -8192.
- Fairness: all 4 requesters hold req_valid high for 8 accepts. Expect grant order 0,1,2,3,0,1,2,3 and rsp_id in the same order, one response per cycle. Then drop requester 1: order becomes 0,2,3.
- Backpressure: fill the pipeline, then hold rsp_ready low for 5 cycles. Expect req_ready all 0, rsp_p and rsp_id frozen, no loss or duplication. After release, the remaining results drain in order.
- Reset: assert ap_rst_n low with 2 operations in flight. Expect rsp_valid = 0 and busy = 0 immediately, without waiting for a clock edge. After release, a new request from requester 3 with 5*7 returns 35 with no stale response first. With all requesters valid, the first grant goes to requester 0.
- Random soak: 10k random operands, modes and ready patterns checked against a reference model of both modes plus an order scoreboard.
